// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer behind the UART receiver. Each rising edge of
//   RxDone pushes RxData into a circular FIFO. The host sees bytes
//   first-word-fall-through through a Valid/ReadEn handshake.
//
// Optional feature macro: UART_RX_FIFO_OVF_CNT_EN
//   defined     : OvfCount is a saturating 8-bit dropped-frame counter
//   not defined : OvfCount is tied to 0
//
// Parameters
//   DEPTH_LOG2 : log2 of FIFO depth (1..8)
//   DATA_W     : byte width
//
// Ports
//   Clk      in   system clock, rising edge
//   Rst      in   asynchronous active-high reset
//   RxDone   in   receiver frame-complete level
//   RxData   in   receiver byte, stable while RxDone is high
//   Flush    in   synchronous clear of contents and status
//   ReadEn   in   pop request, honoured only when Valid
//   ClrOvf   in   synchronous clear of Overflow (and OvfCount)
//   Dout     out  head-of-FIFO byte
//   Valid    out  FIFO non-empty
//   Empty    out  no entries stored
//   Full     out  Count == 2^DEPTH_LOG2
//   Count    out  number of stored entries
//   Overflow out  sticky dropped-frame flag
//   OvfCount out  dropped-frame count (saturating at 255)
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RxDone,
  input  logic [DATA_W-1:0]     RxData,
  input  logic                  Flush,
  input  logic                  ReadEn,
  input  logic                  ClrOvf,
  output logic [DATA_W-1:0]     Dout,
  output logic                  Valid,
  output logic                  Empty,
  output logic                  Full,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overflow,
  output logic [7:0]            OvfCount
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic              d1_q, d2_q;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ovf_q, ovf_d;

  logic push, pop, push_ok, drop, empty, full;

  always_comb begin
    push    = d1_q & ~d2_q;
    empty   = (wp_q == rp_q);
    full    = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop     = ReadEn & ~empty;
    // When full, a same-cycle pop frees the slot being written.
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q;
    if (Flush) begin
      wp_d  = '0;
      rp_d  = '0;
      ovf_d = 1'b0;
    end else begin
      wp_d = wp_q + PW'(push_ok);
      rp_d = rp_q + PW'(pop);
      if (drop) begin
        ovf_d = 1'b1;
      end else if (ClrOvf) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      d1_q  <= 1'b0;
      d2_q  <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      d1_q  <= RxDone;
      d2_q  <= d1_q;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok && !Flush) begin
      mem_q[wp_q[AW-1:0]] <= RxData;
    end
  end

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // A drop coinciding with ClrOvf restarts the count at 1, matching the
  // flag where the set wins.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (Flush) begin
      ovf_cnt_d = '0;
    end else if (ClrOvf) begin
      ovf_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign OvfCount = ovf_cnt_q;
`else
  assign OvfCount = '0;
`endif

  assign Dout     = mem_q[rp_q[AW-1:0]];
  assign Empty    = empty;
  assign Valid    = ~empty;
  assign Full     = full;
  assign Count    = wp_q - rp_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard queue.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

  logic              Clk = 1'b0;
  logic              Rst, RxDone, Flush, ReadEn, ClrOvf;
  logic [DATA_W-1:0] RxData;
  logic [DATA_W-1:0] Dout;
  logic              Valid, Empty, Full, Overflow;
  logic [DEPTH_LOG2:0] Count;
  logic [7:0]        OvfCount;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [7:0]  sb [$];
  int unsigned exp_drops = 0;

  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Rst(Rst), .RxDone(RxDone), .RxData(RxData),
    .Flush(Flush), .ReadEn(ReadEn), .ClrOvf(ClrOvf),
    .Dout(Dout), .Valid(Valid), .Empty(Empty), .Full(Full),
    .Count(Count), .Overflow(Overflow), .OvfCount(OvfCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_ovf_cnt(input int unsigned drops);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    return (drops > 255) ? 8'd255 : drops[7:0];
`else
    return 8'd0;
`endif
  endfunction

  // One frame: RxDone high for 'hold' cycles then low for 3 cycles.
  task automatic send_frame(input logic [7:0] b, input int unsigned hold);
    @(negedge Clk);
    RxData = b;
    RxDone = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(b);
    else exp_drops++;
    repeat (hold) @(negedge Clk);
    RxDone = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  // Back-to-back pops, checking the FWFT head before each.
  task automatic pop_n(input int unsigned n, input string tag);
    logic [7:0] e;
    for (int unsigned i = 0; i < n; i++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      check({tag, "_valid"}, 32'(Valid), 32'd1);
      check({tag, "_dout"}, 32'(Dout), 32'(e));
      ReadEn = 1'b1;
      @(negedge Clk);
    end
    ReadEn = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic ovf);
    check({tag, "_count"}, 32'(Count), 32'(sb.size()));
    check({tag, "_empty"}, 32'(Empty), 32'(sb.size() == 0));
    check({tag, "_valid"}, 32'(Valid), 32'(sb.size() != 0));
    check({tag, "_full"}, 32'(Full), 32'(sb.size() == DEPTH));
    check({tag, "_ovf"}, 32'(Overflow), 32'(ovf));
    check({tag, "_ovfcnt"}, 32'(OvfCount), 32'(exp_ovf_cnt(exp_drops)));
  endtask

  initial begin
    logic [7:0] head;
    Rst = 1'b1; RxDone = 1'b0; RxData = '0; Flush = 1'b0; ReadEn = 1'b0; ClrOvf = 1'b0;
    repeat (2) @(negedge Clk);
    check_status("reset", 1'b0);
    check("reset_dout", 32'(Dout), 32'h0);
    Rst = 1'b0;
    @(negedge Clk);

    // Single frame held 50 cycles: one push, Valid after two edges.
    RxData = 8'hA5; RxDone = 1'b1; sb.push_back(8'hA5);
    @(negedge Clk);
    check("lat_valid_edge1", 32'(Valid), 32'd0);
    @(negedge Clk);
    check("lat_valid_edge2", 32'(Valid), 32'd1);
    check("lat_dout", 32'(Dout), 32'hA5);
    repeat (48) @(negedge Clk);
    RxDone = 1'b0;
    repeat (3) @(negedge Clk);
    check_status("single", 1'b0);
    pop_n(1, "single_pop");
    check_status("single_after", 1'b0);

    // Fill, partial drain, refill across the wrap.
    for (int unsigned i = 0; i < 16; i++) send_frame(8'(i), 2);
    check_status("fill", 1'b0);
    pop_n(4, "wrap_pop4");
    for (int unsigned i = 16; i < 20; i++) send_frame(8'(i), 2);
    check_status("refill", 1'b0);
    pop_n(16, "wrap_pop16");
    check_status("wrap_empty", 1'b0);

    // Overflow: three frames into a full FIFO.
    for (int unsigned i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 2);
    for (int unsigned i = 0; i < 3; i++) send_frame(8'h90 + 8'(i), 2);
    check_status("ovf", 1'b1);
    @(negedge Clk); ClrOvf = 1'b1;
    @(negedge Clk); ClrOvf = 1'b0;
    exp_drops = 0;
    check_status("clrovf", 1'b0);

    // Push pulse coinciding with a pop while full.
    @(negedge Clk);
    RxData = 8'h77; RxDone = 1'b1;
    @(negedge Clk);
    head = sb.pop_front();
    check("simul_head", 32'(Dout), 32'(head));
    sb.push_back(8'h77);
    ReadEn = 1'b1;
    @(negedge Clk);
    ReadEn = 1'b0;
    RxDone = 1'b0;
    repeat (3) @(negedge Clk);
    check_status("simul", 1'b0);
    pop_n(16, "simul_drain");

    // ReadEn while empty changes nothing.
    ReadEn = 1'b1;
    repeat (10) @(negedge Clk);
    ReadEn = 1'b0;
    check_status("rd_empty", 1'b0);
    send_frame(8'h3C, 2);
    check_status("rd_empty_push", 1'b0);
    pop_n(1, "rd_empty_pop");

    // Flush with a coincident push, Count=5 and Overflow set.
    for (int unsigned i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 2);
    pop_n(11, "pre_flush");
    check_status("pre_flush", 1'b1);
    @(negedge Clk);
    RxData = 8'hEE; RxDone = 1'b1;
    @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    sb.delete();
    exp_drops = 0;
    check_status("flush", 1'b0);
    repeat (3) @(negedge Clk);
    RxDone = 1'b0;
    repeat (3) @(negedge Clk);
    check_status("flush_hold", 1'b0);

    // Async reset mid-stream with a push pending.
    for (int unsigned i = 0; i < 3; i++) send_frame(8'h60 + 8'(i), 2);
    send_frame(8'h99, 20);
    exp_drops = 0;
    for (int unsigned i = 0; i < 13; i++) send_frame(8'h70 + 8'(i), 2);
    check_status("pre_rst", 1'b1);
    @(negedge Clk);
    RxData = 8'h5A; RxDone = 1'b1;
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    sb.delete();
    exp_drops = 0;
    check_status("async_rst", 1'b0);
    check("async_rst_dout", 32'(Dout), 32'h0);
    RxDone = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    check_status("post_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
